zelda_sprite_fetch: RTL
=======================

# zelda_sprite_fetch

Per-pixel sprite fetch stage for the player character: takes the VGA scan position and the player's position, facing and motion, and generates the sprite ROM address. It then registers the returned 4-bit colour index into a palette index, a palette select and a hit flag. It sits directly upstream of the per-direction Zelda palette lookups and the colour mux that feeds the VGA output. A frame-synchronous walk-animation state machine selects the image.

## Interface
Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two)
- SPRITE_H, 32, sprite height in pixels (power of two)
- ANIM_DIV, 8, video frames per walk-animation step (1..255)
- TRANSPARENT_IDX, 4'h0, ROM index treated as see-through

Ports:
- Clk  in  1  pixel clock; one clock; all state on rising edge
- Reset_n  in  1  reset, asynchronous assert, active-low
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pix_valid  in  1  DrawX/DrawY in active display this cycle
- DrawX  in  10  scan column
- DrawY  in  10  scan row
- sprite_x  in  10  sprite top-left column
- sprite_y  in  10  sprite top-left row
- dir  in  2  facing: 0 down, 1 up, 2 left, 3 right
- moving  in  1  player walking this frame
- rom_addr  out  log2(SPRITE_W*SPRITE_H)+3  sprite ROM address, registered
- rom_data  in  4  sprite ROM index, synchronous ROM, 1-cycle read latency
- pal_index  out  4  colour index for the palette lookup
- pal_sel  out  3  {dir, frame} selecting the palette module
- sprite_hit  out  1  pixel is opaque sprite pixel
- pix_valid_out  out  1  pix_valid delayed to align with pal_index

## Operation
- Shadow registers dir_q and moving_q load only on frame_start, so the sprite never tears mid-frame. Reset values are down (0) and 0.
- Animation FSM states are STAND, WALK_A and WALK_B. frame = 1 only in WALK_B.
  - STAND→WALK_A at frame_start when moving=1.
  - WALK_A/WALK_B→STAND at frame_start when moving=0.
  - While walking, a frame counter (8-bit) increments per frame_start. On reaching ANIM_DIV-1 it clears and toggles WALK_A↔WALK_B.
  - A dir change at frame_start while walking forces WALK_A and clears the counter.
- Hit box uses 11-bit arithmetic with no wrap:
  - in_box = DrawX>=sprite_x && DrawX<sprite_x+SPRITE_W && DrawY>=sprite_y && DrawY<sprite_y+SPRITE_H.
  - A sprite with sprite_x>640-SPRITE_W clips cleanly.
- Address is {dir_q, frame, row, col}, with row = DrawY-sprite_y and col = DrawX-sprite_x truncated to log2 widths. Outside the box the address holds 0.
- sprite_hit = valid && in_box && rom_data != TRANSPARENT_IDX.
- pal_index = rom_data when hit, else 0.
- pal_sel = {dir_q, frame} as latched when the address was issued.
- frame_start coinciding with pix_valid: that pixel uses the pre-update shadow values. New values apply from the next cycle.

## Timing
- Inputs sampled at the end of cycle N. rom_addr, in_box and valid are visible in N+1. ROM data is valid in N+2. pal_index, pal_sel, sprite_hit and pix_valid_out are visible in N+3. Total latency is 3 cycles, fully pipelined at one pixel per cycle with no stalls.
- Reset (any time, including mid-line): all outputs 0, FSM STAND, counter 0, pipeline valids 0. The first valid output is 3 cycles after the first sampled pix_valid following deassert.
- The FSM and counter change only on cycles with frame_start=1.

## Configuration
- SPRITE_MIRROR_EN defined:
  - dir=left reads the right-facing images with col mirrored (SPRITE_W-1-col).
  - pal_sel reports right (3) for those pixels.
  - The ROM left-image slots are unused.
- Not defined: left reads its own images at dir slot 2, unmirrored.
- Address width and latency are identical in both builds.

## Structure
- zelda_pkg holds:
  - dir_t enum (DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT)
  - anim_state_t (STAND, WALK_A, WALK_B)
  - SCREEN_W=640, SCREEN_H=480, COORD_W=10
- Sub-module zelda_anim_fsm holds the shadow registers, frame counter and FSM, and outputs dir_q and frame. The pipeline and address logic stay in the top.

## Test plan
- Reset mid-frame with pix_valid=1 → all outputs 0 immediately; after release, sprite_x=100, sprite_y=50, dir=0, DrawX=100, DrawY=50 → rom_addr=0 one cycle later, sprite_hit follows 3 cycles after input.
- dir=3, moving=0, DrawX=sprite_x+5, DrawY=sprite_y+2 → rom_addr={2'd3,1'b0,5'd2,5'd5}; rom_data=4'h7 → pal_index=7, pal_sel=6, sprite_hit=1; rom_data=0 → sprite_hit=0, pal_index=0.
- moving=1, ANIM_DIV=8, 20 frame_start pulses → frame stays 0 for frames 1–8 (first pulse enters WALK_A), 1 for frames 9–16, then 0 again.
- dir changes 3→0 while in WALK_B at frame_start → WALK_A and counter 0; dir change with no frame_start → rom_addr dir bits unchanged.
- sprite_x=620, DrawX 615..639 → sprite_hit only for DrawX≥620; DrawX=0 never hits (no wrap).
- SPRITE_MIRROR_EN, dir=2, col=0 → rom_addr dir=3, col=31, pal_sel[2:1]=3; without the macro → dir=2, col=0.

Source files
------------

// File: rtl/zelda_pkg.sv
// Shared types and screen constants for the Zelda player-sprite path.
package zelda_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {STAND, WALK_A, WALK_B} anim_state_t;

endpackage

// File: rtl/zelda_anim_fsm.sv
// Frame-synchronous walk animation: shadow dir/moving registers, step counter and STAND/WALK_A/WALK_B FSM.
module zelda_anim_fsm
    import zelda_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic [1:0] dir,
    input  logic       moving,
    output dir_t       dir_q,
    output logic       frame
);

    localparam logic [7:0] DIV_M1 = 8'(ANIM_DIV - 1);

    anim_state_t state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        moving_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= STAND;
            cnt      <= '0;
            dir_q    <= DIR_DOWN;
            moving_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (frame_start) begin
                dir_q    <= dir_t'(dir);
                moving_q <= moving;
            end
        end
    end

    // moving_q is high exactly while walking, so it doubles as the "already walking" test
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (frame_start) begin
            if (!moving) begin
                state_n = STAND;
                cnt_n   = '0;
            end else if (!moving_q || dir_t'(dir) != dir_q) begin
                state_n = WALK_A;
                cnt_n   = '0;
            end else if (cnt == DIV_M1) begin
                cnt_n   = '0;
                state_n = (state == WALK_B) ? WALK_A : WALK_B;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end
    end

    assign frame = (state == WALK_B);

endmodule

// File: rtl/zelda_sprite_fetch.sv
// Player sprite fetch: hit box, ROM address, 3-cycle pipeline to palette index/select/hit.
// Define SPRITE_MIRROR_EN to draw left-facing frames by mirroring the right-facing images.
module zelda_sprite_fetch
    import zelda_pkg::*;
#(
    parameter int         SPRITE_W        = 32,
    parameter int         SPRITE_H        = 32,
    parameter int         ANIM_DIV        = 8,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic                                  Clk,
    input  logic                                  Reset_n,
    input  logic                                  frame_start,
    input  logic                                  pix_valid,
    input  logic [9:0]                            DrawX,
    input  logic [9:0]                            DrawY,
    input  logic [9:0]                            sprite_x,
    input  logic [9:0]                            sprite_y,
    input  logic [1:0]                            dir,
    input  logic                                  moving,
    output logic [$clog2(SPRITE_W*SPRITE_H)+2:0]  rom_addr,
    input  logic [3:0]                            rom_data,
    output logic [3:0]                            pal_index,
    output logic [2:0]                            pal_sel,
    output logic                                  sprite_hit,
    output logic                                  pix_valid_out
);

    localparam int CW     = $clog2(SPRITE_W);
    localparam int RW     = $clog2(SPRITE_H);
    localparam int STAGES = 3;
    localparam logic [COORD_W:0] SW11 = (COORD_W+1)'(SPRITE_W);
    localparam logic [COORD_W:0] SH11 = (COORD_W+1)'(SPRITE_H);

    dir_t          dir_q, dir_eff;
    logic          frame, mirror, in_box;
    logic [CW-1:0] col, col_eff;
    logic [RW-1:0] row;
    logic [STAGES:1] vld_pipe;
    logic          box1, box2;
    logic [2:0]    sel1, sel2;
    logic          hit_d;

    zelda_anim_fsm #(.ANIM_DIV(ANIM_DIV)) u_anim (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .dir         (dir),
        .moving      (moving),
        .dir_q       (dir_q),
        .frame       (frame)
    );

    // One extra bit so a sprite near the right/bottom edge clips instead of wrapping to 0
    assign in_box = ({1'b0, DrawX} >= {1'b0, sprite_x}) && ({1'b0, DrawX} < {1'b0, sprite_x} + SW11) &&
                    ({1'b0, DrawY} >= {1'b0, sprite_y}) && ({1'b0, DrawY} < {1'b0, sprite_y} + SH11);

    assign col = CW'(DrawX - sprite_x);
    assign row = RW'(DrawY - sprite_y);

`ifdef SPRITE_MIRROR_EN
    assign mirror = (dir_q == DIR_LEFT);
`else
    assign mirror = 1'b0;
`endif

    // SPRITE_W is a power of two, so SPRITE_W-1-col is just ~col
    assign dir_eff = mirror ? DIR_RIGHT : dir_q;
    assign col_eff = mirror ? ~col : col;
    assign hit_d   = vld_pipe[2] && box2 && (rom_data != TRANSPARENT_IDX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_pipe      <= '0;
            rom_addr      <= '0;
            box1          <= 1'b0;
            box2          <= 1'b0;
            sel1          <= '0;
            sel2          <= '0;
            pal_index     <= '0;
            pal_sel       <= '0;
            sprite_hit    <= 1'b0;
            pix_valid_out <= 1'b0;
        end else begin
            vld_pipe      <= {vld_pipe[STAGES-1:1], pix_valid};
            rom_addr      <= in_box ? {dir_eff, frame, row, col_eff} : '0;
            box1          <= in_box;
            sel1          <= {dir_eff, frame};
            box2          <= box1;
            sel2          <= sel1;
            sprite_hit    <= hit_d;
            pal_index     <= hit_d ? rom_data : 4'h0;
            pal_sel       <= sel2;
            pix_valid_out <= vld_pipe[2];
        end
    end

endmodule
